filt_ppi_tdm: RTL and testbench
===============================

FILT_PPI_TDM -- requirements
Module: filt_ppi_tdm

Interface
REQ-001 SHALL have parameter gp_idata_width, default 16, input sample width (signed).
REQ-002 SHALL have parameter gp_coeff_width, default 16, coefficient width (signed).
REQ-003 SHALL have parameter gp_odata_width, default 16, output sample width (signed).
REQ-004 SHALL have parameter gp_interpolation_factor (L), default 4, must be >=2.
REQ-005 SHALL have parameter gp_coeff_length (N), default 16, must be a multiple of L; K = N/L taps per phase.
REQ-006 SHALL have parameter gp_nch, default 2, number of TDM channels, >=1.
REQ-007 SHALL have parameter gp_oshift, default 0, arithmetic right shift applied to the accumulator before saturation.
REQ-008 SHALL have parameter gp_phase_rev, default 0; 1 emits phases L-1..0 instead of 0..L-1.
REQ-009 SHALL have port i_clk, input, 1, the single clock; all logic on rising edge.
REQ-010 SHALL have port i_rst_an, input, 1, asynchronous active-low reset.
REQ-011 SHALL have port i_ena, input, 1, global enable; low freezes all state.
REQ-012 SHALL have ports i_data (input, gp_idata_width) and i_valid (input, 1), input sample and strobe.
REQ-013 SHALL have port o_ready, output, 1, high when an input sample can be accepted.
REQ-014 SHALL have ports i_cwr (input, 1), i_caddr (input, clog2(N)) and i_cdata (input, gp_coeff_width), coefficient write port.
REQ-015 SHALL have ports o_data (output, gp_odata_width), o_valid (output, 1), o_ch (output, clog2(max(gp_nch,2))) and o_phase (output, clog2(L)).

Function
REQ-016 SHALL accept a sample when i_valid & o_ready & i_ena; the sample belongs to channel ch_ptr, which then wraps 0..gp_nch-1.
REQ-017 SHALL keep a per-channel K-deep delay line; on accept, only channel ch_ptr shifts, with x[n] entering at tap 0.
REQ-018 SHALL implement FSM IDLE -> MAC -> OUT -> (MAC for next phase | IDLE after the last phase); o_ready=1 only in IDLE with i_ena=1.
REQ-019 SHALL spend exactly K cycles in MAC per phase, one multiply-accumulate per cycle, with the accumulator cleared on MAC entry.
REQ-020 SHALL compute y_p = sum_{k=0..K-1} h[k*L+p] * x_c[n-k] with full-precision accumulator width gp_idata_width+gp_coeff_width+clog2(K).
REQ-021 SHALL form o_data as (acc >>> gp_oshift) saturated to [-2^(OW-1), 2^(OW-1)-1].
REQ-022 SHALL pulse o_valid for exactly one cycle in OUT, with o_data, o_ch = channel of accepted sample and o_phase = p registered on the same cycle.
REQ-023 SHALL hold o_data, o_ch and o_phase between o_valid pulses.
REQ-024 SHALL give cycle timing relative to an accept at cycle 0: o_valid at cycles m*(K+1), m=1..L; IDLE/o_ready at cycle L*(K+1)+1.
REQ-025 SHALL write h[i_caddr]=i_cdata on i_cwr only in IDLE with i_ena=1; writes in other states or with address >=N are ignored.
REQ-026 SHALL, when i_cwr and an input accept coincide in IDLE, perform both; the new coefficient is used by that sample's computation.
REQ-027 SHALL, with i_ena=0, hold FSM, counters, accumulator, delay lines and coefficients, and force o_valid=0 and o_ready=0.

Reset
REQ-028 SHALL on i_rst_an=0 immediately set o_data=0, o_valid=0, o_ch=0, o_phase=0, state=IDLE, ch_ptr=0, and clear all delay lines, coefficients and the accumulator.
REQ-029 SHALL, on reset asserted mid-operation, abandon the computation with no further o_valid; o_ready=1 on the first enabled cycle after release.

Verification (L=4, N=16, K=4, nch=2, widths 16, gp_oshift=0)
REQ-030 SHALL cover reset: release with i_ena=1 -> o_ready=1, o_valid=0, o_data=0; a reset pulse during MAC -> no o_valid, IDLE afterwards.
REQ-031 SHALL cover impulse: h[i]=i+1; ch0 gets 1 then 0,0,0, ch1 all 0 -> ch0 outputs 1,2,3,4 | 5,6,7,8 | 9..12 | 13..16; ch1 outputs all 0; o_phase 0..3.
REQ-032 SHALL cover latency: accept at cycle 0 -> o_valid at cycles 5,10,15,20 and o_ready at cycle 21; a back-to-back accept at cycle 21 is honoured.
REQ-033 SHALL cover saturation: all h=32767 with sustained x=32767 -> o_data=32767; sustained x=-32768 -> o_data=-32768.
REQ-034 SHALL cover the freeze/ignore rules: i_ena low for 3 cycles mid-MAC shifts all o_valid by 3 cycles with values unchanged; i_cwr during MAC leaves h unchanged.
REQ-035 SHALL cover phase reversal: with gp_phase_rev=1 and the REQ-031 impulse, the first ch0 outputs are 4,3,2,1 with o_phase 3,2,1,0.

Source files
------------

// File: rtl/filt_ppi_tdm.sv
// rtl/filt_ppi_tdm.sv - TDM polyphase interpolating FIR filter with a single serial MAC
//
// Every accepted input sample produces L output samples, one per polyphase
// branch, each computed as K = N/L multiply-accumulates on one multiplier.
// Input samples are time-multiplexed over gp_nch channels, each channel
// keeping its own K-deep delay line.
//
// Ports:
//   i_clk, i_rst_an                 clock (rising edge), asynchronous active-low reset
//   i_ena                           global enable; low freezes every register
//   i_data, i_valid, o_ready        input sample, strobe, ready (IDLE and enabled)
//   i_cwr, i_caddr, i_cdata         coefficient write, honoured only in IDLE
//   o_data, o_valid, o_ch, o_phase  output sample, one-cycle strobe, channel, phase
module filt_ppi_tdm #(
  parameter int gp_idata_width          = 16,
  parameter int gp_coeff_width          = 16,
  parameter int gp_odata_width          = 16,
  parameter int gp_interpolation_factor = 4,
  parameter int gp_coeff_length         = 16,
  parameter int gp_nch                  = 2,
  parameter int gp_oshift               = 0,
  parameter int gp_phase_rev            = 0
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst_an,
  input  logic                                          i_ena,
  input  logic [gp_idata_width-1:0]                     i_data,
  input  logic                                          i_valid,
  output logic                                          o_ready,
  input  logic                                          i_cwr,
  input  logic [$clog2(gp_coeff_length)-1:0]            i_caddr,
  input  logic [gp_coeff_width-1:0]                     i_cdata,
  output logic [gp_odata_width-1:0]                     o_data,
  output logic                                          o_valid,
  output logic [$clog2((gp_nch > 2) ? gp_nch : 2)-1:0]  o_ch,
  output logic [$clog2(gp_interpolation_factor)-1:0]    o_phase
);

  localparam int L   = gp_interpolation_factor;
  localparam int K   = gp_coeff_length / L;
  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  localparam int PW  = gp_idata_width + gp_coeff_width;
  localparam int AW  = PW + $clog2(K);
  localparam int OW  = gp_odata_width;
  localparam int SW  = (AW > OW) ? AW : OW;
  localparam int CAW = $clog2(gp_coeff_length);
  localparam int CHW = $clog2((gp_nch > 2) ? gp_nch : 2);
  localparam int PHW = $clog2(L);

  localparam logic [PHW-1:0] PH_FIRST = (gp_phase_rev != 0) ? PHW'(L - 1) : '0;
  localparam logic [PHW-1:0] PH_LAST  = (gp_phase_rev != 0) ? '0 : PHW'(L - 1);

  // Saturation bounds expressed in the (possibly wider) comparison domain.
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                            state;
  logic [CHW-1:0]                    ch_ptr;
  logic [CHW-1:0]                    cur_ch;
  logic [KW-1:0]                     k_cnt;
  logic [PHW-1:0]                    ph_cnt;
  logic signed [AW-1:0]              acc;
  logic                              valid_q;
  logic signed [gp_idata_width-1:0]  dline [gp_nch][K];
  logic signed [gp_coeff_width-1:0]  coef [gp_coeff_length];

  logic signed [gp_idata_width-1:0]  x_sel;
  logic signed [gp_coeff_width-1:0]  h_sel;
  logic [CAW-1:0]                    h_idx;
  logic signed [PW-1:0]              prod;
  logic signed [AW-1:0]              acc_next;
  logic signed [AW-1:0]              acc_shr;
  logic signed [SW-1:0]              acc_ext;
  logic signed [OW-1:0]              sat_data;
  logic                              coef_wr;

  // Tap k of phase p uses coefficient h[k*L + p].
  always_comb begin
    h_idx = CAW'(int'(k_cnt) * L + int'(ph_cnt));
    x_sel = dline[cur_ch][k_cnt];
    h_sel = coef[h_idx];
  end

  // The last MAC's sum goes straight to the output register, so the value is
  // formed from acc_next rather than waiting a cycle for acc to settle.
  always_comb begin
    prod     = PW'(x_sel) * PW'(h_sel);
    acc_next = acc + AW'(prod);
    acc_shr  = acc_next >>> gp_oshift;
    acc_ext  = SW'(acc_shr);
    if (acc_ext > SAT_MAX) begin
      sat_data = OW'(SAT_MAX);
    end else if (acc_ext < SAT_MIN) begin
      sat_data = OW'(SAT_MIN);
    end else begin
      sat_data = OW'(acc_ext);
    end
  end

  assign coef_wr = (state == S_IDLE) && i_ena && i_cwr &&
                   ({1'b0, i_caddr} < (CAW+1)'(gp_coeff_length));
  assign o_ready = (state == S_IDLE) && i_ena;
  // The strobe register is held while disabled, so gating it here keeps the
  // visible pulse exactly one enabled cycle long.
  assign o_valid = valid_q && i_ena;

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      state   <= S_IDLE;
      ch_ptr  <= '0;
      cur_ch  <= '0;
      k_cnt   <= '0;
      ph_cnt  <= '0;
      acc     <= '0;
      valid_q <= 1'b0;
      o_data  <= '0;
      o_ch    <= '0;
      o_phase <= '0;
      dline   <= '{default: '0};
      coef    <= '{default: '0};
    end else if (i_ena) begin
      valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (coef_wr) begin
            coef[i_caddr] <= i_cdata;
          end
          if (i_valid) begin
            for (int k = K - 1; k > 0; k--) begin
              dline[ch_ptr][KW'(k)] <= dline[ch_ptr][KW'(k - 1)];
            end
            dline[ch_ptr][0] <= i_data;
            cur_ch <= ch_ptr;
            ch_ptr <= (int'(ch_ptr) == gp_nch - 1) ? '0 : ch_ptr + CHW'(1);
            k_cnt  <= '0;
            ph_cnt <= PH_FIRST;
            acc    <= '0;
            state  <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc_next;
          if (int'(k_cnt) == K - 1) begin
            state   <= S_OUT;
            valid_q <= 1'b1;
            o_data  <= sat_data;
            o_ch    <= cur_ch;
            o_phase <= ph_cnt;
          end else begin
            k_cnt <= k_cnt + KW'(1);
          end
        end
        S_OUT: begin
          if (ph_cnt == PH_LAST) begin
            state <= S_IDLE;
          end else begin
            ph_cnt <= (gp_phase_rev != 0) ? ph_cnt - PHW'(1) : ph_cnt + PHW'(1);
            k_cnt  <= '0;
            acc    <= '0;
            state  <= S_MAC;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filt_ppi_tdm.sv
// tb/tb_filt_ppi_tdm.sv - self-checking bench for filt_ppi_tdm (forward and phase-reversed)
module tb_filt_ppi_tdm;
  localparam int L   = 4;
  localparam int N   = 16;
  localparam int K   = 4;
  localparam int NCH = 2;

  typedef struct {
    int data;
    int ch;
    int ph;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n = 1'b0;
  logic               ena = 1'b1;
  logic signed [15:0] data = '0;
  logic               valid = 1'b0;
  logic               cwr = 1'b0;
  logic [3:0]         caddr = '0;
  logic signed [15:0] cdata = '0;

  logic               rdy, vld, rdy_r, vld_r;
  logic signed [15:0] odata, odata_r;
  logic               och, och_r;
  logic [1:0]         oph, oph_r;

  filt_ppi_tdm #(.gp_phase_rev(0)) dut (
    .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_data(data), .i_valid(valid),
    .o_ready(rdy), .i_cwr(cwr), .i_caddr(caddr), .i_cdata(cdata),
    .o_data(odata), .o_valid(vld), .o_ch(och), .o_phase(oph)
  );

  filt_ppi_tdm #(.gp_phase_rev(1)) dut_rev (
    .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_data(data), .i_valid(valid),
    .o_ready(rdy_r), .i_cwr(cwr), .i_caddr(caddr), .i_cdata(cdata),
    .o_data(odata_r), .o_valid(vld_r), .o_ch(och_r), .o_phase(oph_r)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  int   hm [N];
  int   hist [NCH][K];
  int   mch = 0;
  exp_t q[$];
  exp_t qr[$];
  int   cap[$], cap_ph[$], capr[$], capr_ph[$], vcyc[$];

  task automatic chk(string name, int act, int expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic exp_t calc(int c, int p);
    longint s = 0;
    exp_t e;
    for (int k = 0; k < K; k++) s += longint'(hm[k*L + p]) * longint'(hist[c][k]);
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    e.data = int'(s);
    e.ch = c;
    e.ph = p;
    return e;
  endfunction

  task automatic model_accept(int x);
    for (int k = K - 1; k > 0; k--) hist[mch][k] = hist[mch][k-1];
    hist[mch][0] = x;
    for (int m = 0; m < L; m++) begin
      q.push_back(calc(mch, m));
      qr.push_back(calc(mch, L - 1 - m));
    end
    mch = (mch + 1) % NCH;
  endtask

  task automatic model_clear();
    q.delete();
    qr.delete();
    foreach (hm[i]) hm[i] = 0;
    foreach (hist[i, j]) hist[i][j] = 0;
    mch = 0;
  endtask

  // Outputs sampled on the falling edge, away from the active edge.
  int pd = 0, pc = 0, pp = 0, rd = 0, rc = 0, rp = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("reset_o_valid", vld, 0);
      chk("reset_o_data", odata, 0);
      chk("reset_o_ch", och, 0);
      chk("reset_o_phase", oph, 0);
      chk("reset_rev_o_valid", vld_r, 0);
      pd = 0; pc = 0; pp = 0; rd = 0; rc = 0; rp = 0;
    end else begin
      if (!ena) begin
        chk("frozen_o_valid", vld, 0);
        chk("frozen_o_ready", rdy, 0);
      end
      if (vld) begin
        vcyc.push_back(cyc);
        cap.push_back(int'(odata));
        cap_ph.push_back(int'(oph));
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_valid: o_valid=1 with o_data=%0d, expected no output", odata);
        end else begin
          e = q.pop_front();
          chk("o_data", odata, e.data);
          chk("o_ch", och, e.ch);
          chk("o_phase", oph, e.ph);
        end
        pd = odata; pc = och; pp = oph;
      end else begin
        chk("hold_o_data", odata, pd);
        chk("hold_o_ch", och, pc);
        chk("hold_o_phase", oph, pp);
      end
      if (vld_r) begin
        capr.push_back(int'(odata_r));
        capr_ph.push_back(int'(oph_r));
        if (qr.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_valid_rev: o_valid=1 with o_data=%0d, expected no output", odata_r);
        end else begin
          e = qr.pop_front();
          chk("rev_o_data", odata_r, e.data);
          chk("rev_o_ch", och_r, e.ch);
          chk("rev_o_phase", oph_r, e.ph);
        end
        rd = odata_r; rc = och_r; rp = oph_r;
      end else begin
        chk("rev_hold_o_data", odata_r, rd);
        chk("rev_hold_o_phase", oph_r, rp);
        chk("rev_hold_o_ch", och_r, rc);
      end
    end
  end

  task automatic wait_ready(string name);
    int n = 0;
    while (rdy !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (rdy !== 1'b1) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: o_ready=%0b expected 1", name, rdy);
    end
  endtask

  task automatic send(int x, output int tacc);
    wait_ready("send");
    tacc = cyc;
    data = 16'(x);
    valid = 1'b1;
    @(posedge clk);
    model_accept(x);
    #1;
    valid = 1'b0;
    data = '0;
  endtask

  task automatic write_coef(int addr, int val);
    wait_ready("write");
    cwr = 1'b1;
    caddr = 4'(addr);
    cdata = 16'(val);
    @(posedge clk);
    hm[addr] = val;
    #1;
    cwr = 1'b0;
  endtask

  task automatic send_wr(int addr, int val, int x);
    wait_ready("send_wr");
    cwr = 1'b1; caddr = 4'(addr); cdata = 16'(val);
    data = 16'(x); valid = 1'b1;
    @(posedge clk);
    hm[addr] = val;
    model_accept(x);
    #1;
    cwr = 1'b0; valid = 1'b0; data = '0;
  endtask

  task automatic cap_clear();
    cap.delete(); cap_ph.delete(); capr.delete(); capr_ph.delete(); vcyc.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, nsat;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release_o_ready", rdy, 1);
    chk("release_o_valid", vld, 0);
    chk("release_o_data", odata, 0);

    // Impulse through h[i] = i+1
    for (int i = 0; i < N; i++) write_coef(i, i + 1);
    cap_clear();
    send(1, t0);
    for (int i = 0; i < 7; i++) send(0, t0);
    wait_ready("impulse_drain");
    chk("impulse_count", cap.size(), 32);
    if (cap.size() == 32 && capr.size() == 32) begin
      for (int m = 0; m < 4; m++) begin
        chk("impulse_ch0_s0", cap[m], m + 1);
        chk("impulse_ch0_s0_phase", cap_ph[m], m);
        chk("impulse_ch1_zero", cap[4 + m], 0);
        chk("impulse_ch0_s1", cap[8 + m], m + 5);
        chk("impulse_ch0_s2", cap[16 + m], m + 9);
        chk("impulse_ch0_s3", cap[24 + m], m + 13);
        chk("rev_impulse_s0", capr[m], 4 - m);
        chk("rev_impulse_s0_phase", capr_ph[m], 3 - m);
      end
    end

    // Latency and back-to-back accept
    cap_clear();
    send(3, t0);
    wait_ready("latency");
    chk("latency_ready", cyc - t0, 21);
    chk("latency_count", vcyc.size(), 4);
    if (vcyc.size() == 4)
      for (int m = 0; m < 4; m++) chk("latency_valid", vcyc[m] - t0, 5 * (m + 1));
    send(5, t1);
    chk("b2b_accept", t1 - t0, 21);
    wait_ready("b2b_drain");

    // Enable low for three cycles mid-MAC
    cap_clear();
    send(7, t0);
    @(posedge clk); #1;
    ena = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    ena = 1'b1;
    wait_ready("freeze");
    chk("freeze_ready", cyc - t0, 24);
    chk("freeze_count", vcyc.size(), 4);
    if (vcyc.size() == 4)
      for (int m = 0; m < 4; m++) chk("freeze_valid", vcyc[m] - t0, 5 * (m + 1) + 3);

    // Coefficient write during MAC is ignored: ch1 history [2,5,0,0], y0 = 1*2 + 5*5
    cap_clear();
    send(2, t0);
    cwr = 1'b1; caddr = 4'd0; cdata = -16'sd100;
    repeat (2) begin @(posedge clk); #1; end
    cwr = 1'b0;
    wait_ready("cwr_drain");
    chk("cwr_ignored_y0", (cap.size() > 0) ? cap[0] : -1, 27);

    // Write coincident with accept: ch0 history [1,7,3,0], y1 = 10*1 + 6*7 + 10*3
    cap_clear();
    send_wr(1, 10, 1);
    wait_ready("coincident_drain");
    chk("coincident_y1", (cap.size() > 1) ? cap[1] : -1, 82);

    // Reset mid-MAC abandons the computation
    send(9, t0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("async_reset_o_data", odata, 0);
    chk("async_reset_o_valid", vld, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cap_clear();
    chk("post_reset_ready", rdy, 1);
    repeat (30) @(posedge clk);
    #1;
    chk("post_reset_no_valid", vcyc.size(), 0);
    chk("post_reset_idle", rdy, 1);

    // Saturation with all coefficients at full scale
    for (int i = 0; i < N; i++) write_coef(i, 32767);
    cap_clear();
    for (int i = 0; i < 8; i++) send(32767, t0);
    wait_ready("sat_pos");
    nsat = 0;
    foreach (cap[i]) if (cap[i] == 32767) nsat++;
    chk("sat_pos_count", nsat, 32);
    cap_clear();
    for (int i = 0; i < 8; i++) send(-32768, t0);
    wait_ready("sat_neg");
    chk("sat_neg_outputs", cap.size(), 32);
    if (cap.size() == 32)
      for (int i = 24; i < 32; i++) chk("sat_neg", cap[i], -32768);

    repeat (3) @(posedge clk);
    #1;
    chk("drain_queue", q.size(), 0);
    chk("drain_queue_rev", qr.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
